prog_issuer: RTL and testbench

- Drives the 4-bit CPU's instruction interface from the other side. It holds a small loadable program and expected-result memory.
- When started, it steps through the program. For each word it presents the 9-bit Instruction, generates the CPU clock pulse whose negative edge executes it, then samples the CPU's WriteData and compares it against the expected value.
- It sits between the test/host logic and the cpu instance, and turns hand-written stimulus sequences into a self-checking sequencer.

---
 rtl/prog_issuer.sv | 160 ++++++++++++++++
 tb/tb_prog_issuer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prog_issuer.sv
// Program sequencer for the 4-bit CPU: replays a loaded instruction list, generates
// a registered CPU clock pulse per word and scores the returned WriteData.
module prog_issuer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 9,
  parameter int DW    = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadInstr,
  input  logic [DW-1:0] LoadExpect,
  input  logic [AW:0]   ProgLen,
  input  logic          Start,
  input  logic [DW-1:0] WriteData,
  output logic [IW-1:0] Instruction,
  output logic          CpuCLK,
  output logic          Busy,
  output logic          Done,
  output logic [AW-1:0] PC,
  output logic [DW-1:0] LastResult,
  output logic [AW:0]   ErrCount,
  output logic [AW-1:0] FirstErrPC
);

  typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, CHECK} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic          fin, fin_nxt;
  logic [AW-1:0] last_pc, last_pc_nxt;

  logic [IW-1:0] instr_nxt;
  logic          cpu_clk_nxt;
  logic          busy_nxt;
  logic          done_nxt;
  logic [AW-1:0] pc_nxt;
  logic [DW-1:0] last_result_nxt;
  logic [AW:0]   err_count_nxt;
  logic [AW-1:0] first_err_pc_nxt;

  logic [IW+DW-1:0] mem [DEPTH];
  logic [IW-1:0]    mem_instr;
  logic [DW-1:0]    mem_expect;
  logic [AW:0]      len;
  logic             start_ok;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
    return (&v) ? v : v + (AW+1)'(1);
  endfunction

  assign len      = (ProgLen > DEPTH_L) ? DEPTH_L : ProgLen;
  assign {mem_instr, mem_expect} = mem[PC];
  // Done is excluded so a Start coinciding with the end-of-run pulse is dropped.
  assign start_ok = Start && !Busy && !Done;

  // Program memory is deliberately not reset so a run can be repeated after RST.
  always_ff @(posedge CLK) begin
    if (LoadEn && state == IDLE && !Busy) begin
      mem[LoadAddr] <= {LoadInstr, LoadExpect};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= IDLE;
      fin         <= 1'b0;
      last_pc     <= '0;
      Instruction <= '0;
      CpuCLK      <= 1'b0;
      Busy        <= 1'b0;
      Done        <= 1'b0;
      PC          <= '0;
      LastResult  <= '0;
      ErrCount    <= '0;
      FirstErrPC  <= '0;
    end else begin
      state       <= state_nxt;
      fin         <= fin_nxt;
      last_pc     <= last_pc_nxt;
      Instruction <= instr_nxt;
      CpuCLK      <= cpu_clk_nxt;
      Busy        <= busy_nxt;
      Done        <= done_nxt;
      PC          <= pc_nxt;
      LastResult  <= last_result_nxt;
      ErrCount    <= err_count_nxt;
      FirstErrPC  <= first_err_pc_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    fin_nxt          = fin;
    last_pc_nxt      = last_pc;
    instr_nxt        = Instruction;
    cpu_clk_nxt      = CpuCLK;
    busy_nxt         = Busy;
    done_nxt         = 1'b0;
    pc_nxt           = PC;
    last_result_nxt  = LastResult;
    err_count_nxt    = ErrCount;
    first_err_pc_nxt = FirstErrPC;

    unique case (state)
      IDLE: begin
        // fin defers Done by one cycle so it lands 4*len+1 cycles after acceptance.
        if (fin) begin
          done_nxt = 1'b1;
          busy_nxt = 1'b0;
          fin_nxt  = 1'b0;
        end else if (start_ok) begin
          pc_nxt           = '0;
          err_count_nxt    = '0;
          first_err_pc_nxt = '0;
          busy_nxt         = 1'b1;
          last_pc_nxt      = AW'(len - (AW+1)'(1));
          if (len == '0) begin
            fin_nxt = 1'b1;
          end else begin
            state_nxt = SETUP;
          end
        end
      end
      SETUP: begin
        instr_nxt = mem_instr;
        state_nxt = HIGH;
      end
      HIGH: begin
        cpu_clk_nxt = 1'b1;
        state_nxt   = LOW;
      end
      LOW: begin
        cpu_clk_nxt = 1'b0;
        state_nxt   = CHECK;
      end
      CHECK: begin
        last_result_nxt = WriteData;
        if (WriteData != mem_expect) begin
          err_count_nxt = sat_inc(ErrCount);
          if (ErrCount == '0) begin
            first_err_pc_nxt = PC;
          end
        end
        if (PC == last_pc) begin
          fin_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          pc_nxt    = PC + AW'(1);
          state_nxt = SETUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_issuer.sv
// Self-checking bench for prog_issuer; a scripted CPU stand-in returns WriteData on
// each CpuCLK falling edge and a run-level model predicts the scores and timing.
module tb_prog_issuer;
  localparam int DEPTH = 16, AW = 4, IW = 9, DW = 4;

  logic          CLK = 1'b0, RST = 1'b1, LoadEn = 1'b0, Start = 1'b0;
  logic [AW-1:0] LoadAddr = '0;
  logic [IW-1:0] LoadInstr = '0;
  logic [DW-1:0] LoadExpect = '0;
  logic [AW:0]   ProgLen = '0;
  logic [DW-1:0] WriteData = '0;
  logic [IW-1:0] Instruction;
  logic          CpuCLK, Busy, Done;
  logic [AW-1:0] PC, FirstErrPC;
  logic [DW-1:0] LastResult;
  logic [AW:0]   ErrCount;

  always #5 CLK = ~CLK;

  prog_issuer #(.DEPTH(DEPTH), .AW(AW), .IW(IW), .DW(DW)) dut (
    .CLK(CLK), .RST(RST), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadInstr(LoadInstr),
    .LoadExpect(LoadExpect), .ProgLen(ProgLen), .Start(Start), .WriteData(WriteData),
    .Instruction(Instruction), .CpuCLK(CpuCLK), .Busy(Busy), .Done(Done), .PC(PC),
    .LastResult(LastResult), .ErrCount(ErrCount), .FirstErrPC(FirstErrPC)
  );

  // CPU stand-in: each falling CpuCLK edge consumes the next scripted result.
  int            fall_cnt = 0;
  logic [DW-1:0] resp [64];
  logic [IW-1:0] seen [64];
  always @(negedge CpuCLK) begin
    WriteData <= resp[fall_cnt % 64];
    seen[fall_cnt % 64] <= Instruction;
    fall_cnt <= fall_cnt + 1;
  end

  // Model of program memory and the value the CPU returns for each entry.
  logic [IW-1:0] m_i [DEPTH];
  logic [DW-1:0] m_e [DEPTH];
  logic [DW-1:0] c_r [DEPTH];

  int n_chk = 0, n_pass = 0;
  int r_done, r_falls, r_f0;
  bit r_busy_ok;

  localparam logic [IW-1:0] P_I [7] = '{9'b100111110, 9'b100100011, 9'b000101101,
    9'b110011011, 9'b010101101, 9'b110110110, 9'b001011011};
  localparam logic [DW-1:0] P_E [7] = '{4'b1111, 4'b1000, 4'b1000, 4'b1001,
    4'b1000, 4'b0001, 4'b1001};

  task automatic load(input int a, input logic [IW-1:0] ins, input logic [DW-1:0] ex);
    @(negedge CLK);
    LoadEn = 1'b1; LoadAddr = AW'(a); LoadInstr = ins; LoadExpect = ex;
    @(posedge CLK); #1;
    LoadEn = 1'b0;
    m_i[a] = ins; m_e[a] = ex;
  endtask

  // Drives one run and measures it; stray Start and a busy-time load are optional.
  task automatic do_run(input int plen, input int stray, input int ld_cyc,
                        input logic [DW-1:0] ld_exp);
    int cyc;
    for (int i = 0; i < DEPTH; i++) resp[(fall_cnt + i) % 64] = c_r[i];
    @(negedge CLK);
    ProgLen = (AW+1)'(plen); Start = 1'b1; r_f0 = fall_cnt;
    @(posedge CLK); @(negedge CLK);
    Start = 1'b0; cyc = 0; r_done = -1; r_busy_ok = 1'b1;
    while (cyc < 300) begin
      Start = (cyc == stray);
      LoadEn = (cyc == ld_cyc); LoadAddr = 4'd5; LoadInstr = '1; LoadExpect = ld_exp;
      @(posedge CLK); cyc++; @(negedge CLK);
      if (Done) begin r_done = cyc; break; end
      if (!Busy) r_busy_ok = 1'b0;
    end
    Start = 1'b0; LoadEn = 1'b0;
    r_falls = fall_cnt - r_f0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK); RST = 1'b0;
    @(posedge CLK); @(negedge CLK);
    n_chk++; if (Instruction !== '0) $display("FAIL reset_instr got=%0h want=0", Instruction); else n_pass++;
    n_chk++; if ({CpuCLK, Busy, Done} !== 3'b000) $display("FAIL reset_ctl got=%b want=000", {CpuCLK, Busy, Done}); else n_pass++;
    n_chk++; if (PC !== '0) $display("FAIL reset_pc got=%0d want=0", PC); else n_pass++;
    n_chk++; if (LastResult !== '0) $display("FAIL reset_last got=%0d want=0", LastResult); else n_pass++;
    n_chk++; if (ErrCount !== '0 || FirstErrPC !== '0) $display("FAIL reset_err got=%0d/%0d want=0/0", ErrCount, FirstErrPC); else n_pass++;
  endtask

  task automatic test_program();
    int bad;
    for (int i = 0; i < 7; i++) begin load(i, P_I[i], P_E[i]); c_r[i] = P_E[i]; end
    do_run(7, -1, -1, '0);
    n_chk++; if (r_done !== 29) $display("FAIL prog_done_cycle got=%0d want=29", r_done); else n_pass++;
    n_chk++; if (r_falls !== 7) $display("FAIL prog_falls got=%0d want=7", r_falls); else n_pass++;
    n_chk++; if (ErrCount !== 0) $display("FAIL prog_errcount got=%0d want=0", ErrCount); else n_pass++;
    n_chk++; if (LastResult !== 4'b1001) $display("FAIL prog_last got=%b want=1001", LastResult); else n_pass++;
    n_chk++; if (PC !== 4'd6 || Busy !== 1'b0) $display("FAIL prog_pc_busy got=%0d/%b want=6/0", PC, Busy); else n_pass++;
    n_chk++; if (!r_busy_ok) $display("FAIL prog_busy_during got=0 want=1"); else n_pass++;
    bad = 0;
    for (int i = 0; i < 7; i++) if (seen[(r_f0 + i) % 64] !== m_i[i]) bad++;
    n_chk++; if (bad != 0) $display("FAIL prog_instr_seq got=%0d wrong want=0", bad); else n_pass++;
    @(posedge CLK); @(negedge CLK);
    n_chk++; if (Done !== 1'b0 || Instruction !== m_i[6]) $display("FAIL prog_after got=%b/%0h want=0/%0h", Done, Instruction, m_i[6]); else n_pass++;
  endtask

  task automatic test_error();
    load(3, P_I[3], 4'b0000);
    do_run(7, -1, -1, '0);
    n_chk++; if (ErrCount !== 1) $display("FAIL err_count got=%0d want=1", ErrCount); else n_pass++;
    n_chk++; if (FirstErrPC !== 4'd3) $display("FAIL err_first got=%0d want=3", FirstErrPC); else n_pass++;
    n_chk++; if (r_falls !== 7 || r_done !== 29) $display("FAIL err_run got=%0d/%0d want=7/29", r_falls, r_done); else n_pass++;
    n_chk++; if (LastResult !== 4'b1001) $display("FAIL err_last got=%b want=1001", LastResult); else n_pass++;
    load(3, P_I[3], P_E[3]);
  endtask

  task automatic test_zero_len();
    do_run(0, -1, -1, '0);
    n_chk++; if (r_done !== 1) $display("FAIL zero_done_cycle got=%0d want=1", r_done); else n_pass++;
    n_chk++; if (r_falls !== 0) $display("FAIL zero_falls got=%0d want=0", r_falls); else n_pass++;
    n_chk++; if (ErrCount !== 0 || Busy !== 1'b0) $display("FAIL zero_err_busy got=%0d/%b want=0/0", ErrCount, Busy); else n_pass++;
  endtask

  task automatic test_overlong();
    for (int i = 7; i < DEPTH; i++) begin
      load(i, IW'($urandom), DW'($urandom));
      c_r[i] = m_e[i];
    end
    do_run(20, 10, -1, '0);
    n_chk++; if (r_done !== 65) $display("FAIL long_done_cycle got=%0d want=65", r_done); else n_pass++;
    n_chk++; if (PC !== 4'd15) $display("FAIL long_pc got=%0d want=15", PC); else n_pass++;
    n_chk++; if (r_falls !== 16 || ErrCount !== 0) $display("FAIL long_run got=%0d/%0d want=16/0", r_falls, ErrCount); else n_pass++;
  endtask

  task automatic test_reset_midrun();
    for (int i = 0; i < DEPTH; i++) resp[(fall_cnt + i) % 64] = c_r[i];
    @(negedge CLK); ProgLen = 7; Start = 1'b1;
    @(posedge CLK); @(negedge CLK); Start = 1'b0;
    repeat (10) begin @(posedge CLK); @(negedge CLK); end
    n_chk++; if (CpuCLK !== 1'b1 || PC !== 4'd2) $display("FAIL rst_mid_pre got=%b/%0d want=1/2", CpuCLK, PC); else n_pass++;
    RST = 1'b1;
    @(posedge CLK); @(negedge CLK);
    RST = 1'b0;
    n_chk++; if ({CpuCLK, Busy, Done} !== 3'b000) $display("FAIL rst_mid_ctl got=%b want=000", {CpuCLK, Busy, Done}); else n_pass++;
    n_chk++; if (PC !== '0 || ErrCount !== '0) $display("FAIL rst_mid_pc_err got=%0d/%0d want=0/0", PC, ErrCount); else n_pass++;
    do_run(7, -1, -1, '0);
    n_chk++; if (r_falls !== 7 || ErrCount !== 0) $display("FAIL rst_rerun got=%0d/%0d want=7/0", r_falls, ErrCount); else n_pass++;
    n_chk++; if (LastResult !== 4'b1001) $display("FAIL rst_rerun_last got=%b want=1001", LastResult); else n_pass++;
  endtask

  task automatic test_load_while_busy();
    do_run(7, -1, 8, ~P_E[5]);
    n_chk++; if (ErrCount !== 0) $display("FAIL busyload_run1 got=%0d want=0", ErrCount); else n_pass++;
    do_run(7, -1, -1, '0);
    n_chk++; if (ErrCount !== 0) $display("FAIL busyload_run2 got=%0d want=0", ErrCount); else n_pass++;
    n_chk++; if (seen[(r_f0 + 5) % 64] !== P_I[5]) $display("FAIL busyload_instr5 got=%0h want=%0h", seen[(r_f0 + 5) % 64], P_I[5]); else n_pass++;
  endtask

  task automatic test_random();
    int plen, len, errs, first;
    for (int i = 0; i < DEPTH; i++) begin
      load(i, IW'($urandom), DW'($urandom));
      c_r[i] = ($urandom_range(0, 1) == 1) ? m_e[i] : DW'($urandom);
    end
    for (int it = 0; it < 5; it++) begin
      plen = $urandom_range(1, 24);
      len = (plen > DEPTH) ? DEPTH : plen;
      errs = 0; first = 0;
      for (int i = 0; i < len; i++) if (c_r[i] != m_e[i]) begin
        if (errs == 0) first = i;
        errs++;
      end
      do_run(plen, -1, -1, '0);
      n_chk++; if (r_done !== 4 * len + 1) $display("FAIL rnd_done it=%0d got=%0d want=%0d", it, r_done, 4 * len + 1); else n_pass++;
      n_chk++; if (ErrCount !== (AW+1)'(errs)) $display("FAIL rnd_err it=%0d got=%0d want=%0d", it, ErrCount, errs); else n_pass++;
      n_chk++; if (FirstErrPC !== AW'(first)) $display("FAIL rnd_first it=%0d got=%0d want=%0d", it, FirstErrPC, first); else n_pass++;
      n_chk++; if (LastResult !== c_r[len-1] || PC !== AW'(len - 1)) $display("FAIL rnd_last_pc it=%0d got=%0d/%0d want=%0d/%0d", it, LastResult, PC, c_r[len-1], len - 1); else n_pass++;
      n_chk++; if (r_falls !== len) $display("FAIL rnd_falls it=%0d got=%0d want=%0d", it, r_falls, len); else n_pass++;
      for (int i = 0; i < DEPTH; i++) c_r[i] = ($urandom_range(0, 2) != 0) ? m_e[i] : DW'($urandom);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) resp[i] = '0;
    for (int i = 0; i < DEPTH; i++) begin m_i[i] = '0; m_e[i] = '0; c_r[i] = '0; end
    test_reset();
    test_program();
    test_error();
    test_zero_len();
    test_overlong();
    test_reset_midrun();
    test_load_while_busy();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
